// File: rtl/mem_seq_pkg.sv
// Shared definitions for the mem_seq block: access-mode encodings and
// default width parameters.
package mem_seq_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 5;

    // Access modes; the reserved encoding behaves as RANDOM.
    typedef enum logic [1:0] {
        MODE_RANDOM  = 2'b00,
        MODE_AUTOINC = 2'b01,
        MODE_FIFO    = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

endpackage

// File: rtl/mem_seq_if.sv
// Request/response bundle of mem_seq. The master drives requests, the
// slave (mem_seq) returns read data, flags and FIFO occupancy.
//
// Handshake: requests (wr_en, rd_en, ptr_load, clr_err) have no ready;
// each is sampled on every rising edge and either accepted or dropped
// (drops in FIFO mode raise err). rdata_valid is a one-cycle valid with
// no ready: it pulses in the cycle right after the edge that accepted a
// read, and rdata holds until the next accepted read.
interface mem_seq_if
    import mem_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic [1:0]        mode;
    logic              wr_en;
    logic              rd_en;
    logic              ptr_load;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              clr_err;
    logic [DATA_W-1:0] rdata;
    logic              rdata_valid;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              err;

    modport master (
        output mode, wr_en, rd_en, ptr_load, addr, wdata, clr_err,
        input  rdata, rdata_valid, full, empty, count, err
    );

    modport slave (
        input  mode, wr_en, rd_en, ptr_load, addr, wdata, clr_err,
        output rdata, rdata_valid, full, empty, count, err
    );

endinterface

// File: rtl/mem_seq_ram.sv
// DEPTH x DATA_W storage with a synchronous write port and a registered
// read port. A read and a write to the same word in one cycle return the
// old word. Only the read register is reset; the array is not.
module mem_seq_ram
    import mem_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Array write; contents are left uninitialised and survive resets.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register samples the pre-write contents and holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/mem_seq.sv
// Memory sequencer: one RAM accessed as random-access, auto-incrementing
// or FIFO storage. All pointer, mode and flag logic lives here.
module mem_seq
    import mem_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic     clk,
    input  logic     rst_n,
    mem_seq_if.slave bus
);

    localparam logic [ADDR_W:0]   FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);

    mode_e             mode_q;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_q;
    logic              err_q;
    logic              rvalid_q;

    logic              mode_chg;
    logic              is_fifo;
    logic              cnt_full;
    logic              cnt_empty;
    logic              ram_we;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_waddr;
    logic [ADDR_W-1:0] ram_raddr;
    logic [DATA_W-1:0] ram_rdata;
    logic              push;
    logic              pop;
    logic              err_set;
    logic              ptr_adv;
    logic              ptr_ld;

    assign mode_chg  = (bus.mode != mode_q);
    assign is_fifo   = (mode_q == MODE_FIFO);
    assign cnt_full  = (count_q == FULL_CNT);
    assign cnt_empty = (count_q == '0);

    // Request decode: route addresses and accept/drop requests per mode.
    // A mode-change cycle ignores every request.
    always_comb begin
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_waddr = bus.addr;
        ram_raddr = bus.addr;
        push      = 1'b0;
        pop       = 1'b0;
        err_set   = 1'b0;
        ptr_adv   = 1'b0;
        ptr_ld    = 1'b0;
        if (!mode_chg) begin
            case (mode_q)
                MODE_AUTOINC: begin
                    ram_waddr = ptr;
                    ram_raddr = ptr;
                    if (bus.ptr_load) begin
                        ptr_ld = 1'b1;
                    end else begin
                        ram_we  = bus.wr_en;
                        ram_re  = bus.rd_en;
                        ptr_adv = bus.wr_en | bus.rd_en;
                    end
                end
                MODE_FIFO: begin
                    // A pop frees a slot in the same cycle, so push+pop
                    // on a full FIFO both go through.
                    push      = bus.wr_en & (~cnt_full | bus.rd_en);
                    pop       = bus.rd_en & ~cnt_empty;
                    err_set   = (bus.wr_en & cnt_full & ~bus.rd_en) |
                                (bus.rd_en & cnt_empty);
                    ram_we    = push;
                    ram_re    = pop;
                    ram_waddr = wr_ptr;
                    ram_raddr = rd_ptr;
                end
                default: begin
                    ram_we = bus.wr_en;
                    ram_re = bus.rd_en;
                end
            endcase
        end
    end

    // Mode register, pointers and FIFO occupancy; a mode change clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= MODE_RANDOM;
            ptr     <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (mode_chg) begin
            mode_q  <= mode_e'(bus.mode);
            ptr     <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (ptr_ld) begin
                ptr <= bus.addr;
            end else if (ptr_adv) begin
                ptr <= ptr + PTR_ONE;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_ONE;
            end else if (pop && !push) begin
                count_q <= count_q - CNT_ONE;
            end
        end
    end

    // Sticky error; a new error in the clearing cycle keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end else if (bus.clr_err) begin
            err_q <= 1'b0;
        end
    end

    // Read-valid pulse aligned with the RAM read register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= ram_re;
        end
    end

    mem_seq_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (bus.wdata),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    assign bus.rdata       = ram_rdata;
    assign bus.rdata_valid = rvalid_q;
    assign bus.full        = is_fifo & cnt_full;
    assign bus.empty       = is_fifo & cnt_empty;
    assign bus.count       = is_fifo ? count_q : '0;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_mem_seq.sv
// Directed bench for mem_seq (DATA_W=8, ADDR_W=5): random, auto-increment
// and FIFO access, error flag, mode switching and asynchronous reset.
module tb_mem_seq;
    import mem_seq_pkg::*;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    logic [7:0] exp_q[$];
    logic [7:0] e;

    mem_seq_if #(.DATA_W(8), .ADDR_W(5)) bus ();

    mem_seq #(.DATA_W(8), .ADDR_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock: 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are then stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_en    = 1'b0;
        bus.rd_en    = 1'b0;
        bus.ptr_load = 1'b0;
        bus.clr_err  = 1'b0;
    endtask

    // One request cycle, then return the request lines to idle.
    task automatic cyc(input logic w, input logic r, input logic l, input logic c,
                       input logic [4:0] a, input logic [7:0] d);
        bus.wr_en    = w;
        bus.rd_en    = r;
        bus.ptr_load = l;
        bus.clr_err  = c;
        bus.addr     = a;
        bus.wdata    = d;
        tick();
        idle();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        bus.mode    = MODE_RANDOM;
        bus.addr    = '0;
        bus.wdata   = '0;
        idle();

        // Reset state
        tick();
        tick();
        chk("rst_rdata", 32'(bus.rdata), 32'h00);
        chk("rst_valid", 32'(bus.rdata_valid), 32'h0);
        chk("rst_err", 32'(bus.err), 32'h0);
        chk("rst_count", 32'(bus.count), 32'h0);
        chk("rst_full", 32'(bus.full), 32'h0);
        chk("rst_empty", 32'(bus.empty), 32'h0);
        rst_n = 1'b1;
        tick();

        // RANDOM: write, read, read-before-write, hold
        cyc(1, 0, 0, 0, 5'd3, 8'hA5);
        chk("rnd_wr_novalid", 32'(bus.rdata_valid), 32'h0);
        cyc(0, 1, 0, 0, 5'd3, 8'h00);
        chk("rnd_rd_data", 32'(bus.rdata), 32'hA5);
        chk("rnd_rd_valid", 32'(bus.rdata_valid), 32'h1);
        tick();
        chk("rnd_valid_pulse", 32'(bus.rdata_valid), 32'h0);
        chk("rnd_rdata_hold", 32'(bus.rdata), 32'hA5);
        cyc(1, 1, 0, 0, 5'd3, 8'h5A);
        chk("rnd_rbw_old", 32'(bus.rdata), 32'hA5);
        cyc(0, 1, 0, 0, 5'd3, 8'h00);
        chk("rnd_rbw_new", 32'(bus.rdata), 32'h5A);
        chk("rnd_count0", 32'(bus.count), 32'h0);

        // AUTOINC: load 30, write three words across the wrap
        bus.mode = MODE_AUTOINC;
        tick();
        cyc(0, 0, 1, 0, 5'd30, 8'h00);
        cyc(1, 0, 0, 0, 5'd0, 8'h11);
        cyc(1, 0, 0, 0, 5'd0, 8'h22);
        cyc(1, 0, 0, 0, 5'd0, 8'h33);
        cyc(1, 0, 1, 0, 5'd30, 8'hFF);
        chk("ai_load_suppress_valid", 32'(bus.rdata_valid), 32'h0);
        cyc(0, 1, 0, 0, 5'd0, 8'h00);
        chk("ai_rd0", 32'(bus.rdata), 32'h11);
        chk("ai_rd0_valid", 32'(bus.rdata_valid), 32'h1);
        cyc(0, 1, 0, 0, 5'd0, 8'h00);
        chk("ai_rd1", 32'(bus.rdata), 32'h22);
        cyc(0, 1, 0, 0, 5'd0, 8'h00);
        chk("ai_rd2_wrap", 32'(bus.rdata), 32'h33);
        // Simultaneous write+read advances the pointer once
        cyc(0, 0, 1, 0, 5'd5, 8'h00);
        cyc(1, 0, 0, 0, 5'd0, 8'h44);
        cyc(1, 0, 0, 0, 5'd0, 8'h66);
        cyc(0, 0, 1, 0, 5'd5, 8'h00);
        cyc(1, 1, 0, 0, 5'd0, 8'h55);
        chk("ai_wr_rd_old", 32'(bus.rdata), 32'h44);
        cyc(0, 1, 0, 0, 5'd0, 8'h00);
        chk("ai_single_adv", 32'(bus.rdata), 32'h66);
        cyc(0, 0, 1, 0, 5'd5, 8'h00);
        cyc(0, 1, 0, 0, 5'd0, 8'h00);
        chk("ai_wr_rd_new", 32'(bus.rdata), 32'h55);

        // Confirm AUTOINC placement through RANDOM reads
        bus.mode = MODE_RANDOM;
        tick();
        cyc(0, 1, 0, 0, 5'd0, 8'h00);
        chk("rnd_mem0", 32'(bus.rdata), 32'h33);
        cyc(0, 1, 0, 0, 5'd31, 8'h00);
        chk("rnd_mem31", 32'(bus.rdata), 32'h22);
        cyc(0, 1, 0, 0, 5'd30, 8'h00);
        chk("rnd_mem30_no_ff", 32'(bus.rdata), 32'h11);

        // FIFO: fill, overflow, clear, push+pop full, drain
        bus.mode = MODE_FIFO;
        tick();
        chk("ff_init_empty", 32'(bus.empty), 32'h1);
        chk("ff_init_count", 32'(bus.count), 32'h0);
        chk("ff_init_full", 32'(bus.full), 32'h0);
        for (int i = 0; i < 32; i++) begin
            cyc(1, 0, 0, 0, 5'd0, 8'(i));
            exp_q.push_back(8'(i));
        end
        chk("ff_fill_count", 32'(bus.count), 32'd32);
        chk("ff_fill_full", 32'(bus.full), 32'h1);
        chk("ff_fill_empty", 32'(bus.empty), 32'h0);
        chk("ff_fill_err", 32'(bus.err), 32'h0);
        cyc(1, 0, 0, 0, 5'd0, 8'hEE);
        chk("ff_ovf_err", 32'(bus.err), 32'h1);
        chk("ff_ovf_count", 32'(bus.count), 32'd32);
        cyc(0, 0, 0, 1, 5'd0, 8'h00);
        chk("ff_clr_err", 32'(bus.err), 32'h0);
        cyc(1, 1, 0, 0, 5'd0, 8'h20);
        exp_q.push_back(8'h20);
        e = exp_q.pop_front();
        chk("ff_full_pp_data", 32'(bus.rdata), 32'(e));
        chk("ff_full_pp_valid", 32'(bus.rdata_valid), 32'h1);
        chk("ff_full_pp_count", 32'(bus.count), 32'd32);
        chk("ff_full_pp_err", 32'(bus.err), 32'h0);
        for (int i = 0; i < 32; i++) begin
            cyc(0, 1, 0, 0, 5'd0, 8'h00);
            e = exp_q.pop_front();
            chk("ff_drain_data", 32'(bus.rdata), 32'(e));
            chk("ff_drain_valid", 32'(bus.rdata_valid), 32'h1);
        end
        chk("ff_drain_empty", 32'(bus.empty), 32'h1);
        chk("ff_drain_count", 32'(bus.count), 32'h0);
        chk("ff_drain_full", 32'(bus.full), 32'h0);

        // FIFO: underflow, push+pop on empty, set-wins clear
        cyc(0, 1, 0, 0, 5'd0, 8'h00);
        chk("ff_udf_valid", 32'(bus.rdata_valid), 32'h0);
        chk("ff_udf_err", 32'(bus.err), 32'h1);
        chk("ff_udf_rdata_hold", 32'(bus.rdata), 32'h20);
        cyc(0, 0, 0, 1, 5'd0, 8'h00);
        chk("ff_udf_clr", 32'(bus.err), 32'h0);
        cyc(1, 1, 0, 0, 5'd0, 8'h77);
        chk("ff_empty_pp_err", 32'(bus.err), 32'h1);
        chk("ff_empty_pp_count", 32'(bus.count), 32'h1);
        chk("ff_empty_pp_valid", 32'(bus.rdata_valid), 32'h0);
        cyc(0, 1, 0, 0, 5'd0, 8'h00);
        chk("ff_empty_pp_data", 32'(bus.rdata), 32'h77);
        chk("ff_empty_pp_drain", 32'(bus.count), 32'h0);
        cyc(0, 1, 0, 1, 5'd0, 8'h00);
        chk("ff_set_wins", 32'(bus.err), 32'h1);
        cyc(0, 0, 0, 1, 5'd0, 8'h00);
        chk("ff_clr_after", 32'(bus.err), 32'h0);

        // Mode switch FIFO(5) -> RANDOM -> FIFO; addr 9 holds 0x09 from the fill
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 0, 0, 5'd0, 8'(8'h90 + i));
        end
        chk("sw_count5", 32'(bus.count), 32'd5);
        bus.mode = MODE_RANDOM;
        cyc(1, 0, 0, 0, 5'd9, 8'hBD);
        chk("sw_rnd_count", 32'(bus.count), 32'h0);
        chk("sw_rnd_empty", 32'(bus.empty), 32'h0);
        cyc(0, 1, 0, 0, 5'd9, 8'h00);
        chk("sw_no_write", 32'(bus.rdata), 32'h09);
        bus.mode = MODE_FIFO;
        cyc(1, 0, 0, 0, 5'd0, 8'hBE);
        chk("sw_ff_count", 32'(bus.count), 32'h0);
        chk("sw_ff_empty", 32'(bus.empty), 32'h1);
        cyc(1, 0, 0, 0, 5'd0, 8'hC1);
        chk("sw_ff_push", 32'(bus.count), 32'h1);
        cyc(0, 1, 0, 0, 5'd0, 8'h00);
        chk("sw_ff_pop", 32'(bus.rdata), 32'hC1);

        // Reset mid-burst with count=7 and a read pending
        for (int i = 0; i < 7; i++) begin
            cyc(1, 0, 0, 0, 5'd0, 8'(8'hA0 + i));
        end
        chk("mr_count7", 32'(bus.count), 32'd7);
        bus.rd_en = 1'b1;
        #3;
        rst_n    = 1'b0;
        bus.mode = MODE_RANDOM;
        #1;
        chk("mr_rdata0", 32'(bus.rdata), 32'h00);
        chk("mr_valid0", 32'(bus.rdata_valid), 32'h0);
        chk("mr_count0", 32'(bus.count), 32'h0);
        chk("mr_err0", 32'(bus.err), 32'h0);
        tick();
        chk("mr_in_reset_valid", 32'(bus.rdata_valid), 32'h0);
        tick();
        idle();
        rst_n = 1'b1;
        tick();
        chk("mr_release_valid", 32'(bus.rdata_valid), 32'h0);
        chk("mr_release_rdata", 32'(bus.rdata), 32'h00);
        bus.mode = MODE_FIFO;
        tick();
        chk("mr_fifo_count", 32'(bus.count), 32'h0);
        chk("mr_fifo_empty", 32'(bus.empty), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
